// File: rtl/up_down_counter_mod.sv
// Parametrised up/down counter: clear > load > step > hold, wrap or saturate at bounds.
// Optional enable prescaler is compiled in with `define COUNTER_PRESCALE_EN.
module up_down_counter_mod #(
  parameter int WIDTH     = 8,
  parameter int MAX_VALUE = 2**WIDTH - 1,
  parameter int SATURATE  = 0,
  parameter int PRESCALE  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VALUE);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   cnt_ext;
  logic             step;

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  assign step = enable && (pre_q == PRE_LAST);

  // Phase restarts on clear or load so the next step is a full PRESCALE away.
  always_comb begin
    pre_d = pre_q;
    if (clear || load)   pre_d = '0;
    else if (step)       pre_d = '0;
    else if (enable)     pre_d = pre_q + PW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pre_q <= '0;
    else          pre_q <= pre_d;
  end
`else
  assign step = enable;
`endif

  assign cnt_ext = {1'b0, count_q};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = ({1'b0, data} > MAX_EXT) ? MAX_W : data;
    end else if (step) begin
      if (up) begin
        if (cnt_ext > MAX_EXT) begin
          count_d = MAX_W;
        end else if (cnt_ext == MAX_EXT) begin
          wrap_d  = 1'b1;
          count_d = (SATURATE != 0) ? count_q : '0;
        end else begin
          count_d = WIDTH'(cnt_ext + ONE_EXT);
        end
      end else begin
        // An out-of-range state can only come from X; recover just below the top.
        if (cnt_ext > MAX_EXT) begin
          count_d = MAX_W - WIDTH'(1);
        end else if (cnt_ext == '0) begin
          wrap_d  = 1'b1;
          count_d = (SATURATE != 0) ? count_q : MAX_W;
        end else begin
          count_d = WIDTH'(cnt_ext - ONE_EXT);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out  = count_q;
  assign wrap = wrap_q;
  assign tc   = up ? (count_q == MAX_W) : (count_q == '0);

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Directed bench for up_down_counter_mod: four configurations share one stimulus bus,
// plus a prescaler instance and a reference-model soak on the 4-bit instance.
module tb_up_down_counter_mod;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] data = 8'd0;
  logic       enable = 1'b0;
  logic       up = 1'b1;

  logic [7:0] out_full, out_dut, out_sat, out_pre;
  logic [3:0] out_w4;
  logic       tc_full, tc_dut, tc_sat, tc_pre, tc_w4;
  logic       wrap_full, wrap_dut, wrap_sat, wrap_pre, wrap_w4;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  up_down_counter_mod #(.WIDTH(8), .MAX_VALUE(255), .SATURATE(0), .PRESCALE(1)) u_full (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .data(data),
    .enable(enable), .up(up), .out(out_full), .tc(tc_full), .wrap(wrap_full));

  up_down_counter_mod #(.WIDTH(8), .MAX_VALUE(9), .SATURATE(0), .PRESCALE(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .data(data),
    .enable(enable), .up(up), .out(out_dut), .tc(tc_dut), .wrap(wrap_dut));

  up_down_counter_mod #(.WIDTH(8), .MAX_VALUE(9), .SATURATE(1), .PRESCALE(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .data(data),
    .enable(enable), .up(up), .out(out_sat), .tc(tc_sat), .wrap(wrap_sat));

  up_down_counter_mod #(.WIDTH(4), .MAX_VALUE(15), .SATURATE(0), .PRESCALE(1)) u_w4 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .data(data[3:0]),
    .enable(enable), .up(up), .out(out_w4), .tc(tc_w4), .wrap(wrap_w4));

  up_down_counter_mod #(.WIDTH(8), .MAX_VALUE(255), .SATURATE(0), .PRESCALE(4)) u_pre (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .data(data),
    .enable(enable), .up(up), .out(out_pre), .tc(tc_pre), .wrap(wrap_pre));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic test_reset();
    #2;
    chk("reset_out_before_release", out_full, 8'd0);
    chk("reset_wrap_before_release", {7'd0, wrap_dut}, 8'd0);
    #21 reset_n = 1'b1;
    tick();
    chk("reset_out_after_release", out_full, 8'd0);
    load = 1'b1; data = 8'h36;
    tick();
    load = 1'b0; enable = 1'b1; up = 1'b1;
    tick();
    chk("precount_full", out_full, 8'h37);
    chk("precount_dut_wrap", {7'd0, wrap_dut}, 8'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset_out", out_full, 8'd0);
    chk("async_reset_wrap", {7'd0, wrap_dut}, 8'd0);
    enable = 1'b0;
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_after_release", out_full, 8'd0);
    end
  endtask

  task automatic test_up_wrap();
    clear = 1'b1; tick(); clear = 1'b0;
    enable = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] e;
      e = 8'((i + 1) % 10);
      tick();
      chk("up_out", out_dut, e);
      chk("up_wrap", {7'd0, wrap_dut}, {7'd0, e == 8'd0});
      chk("up_tc", {7'd0, tc_dut}, {7'd0, e == 8'd9});
    end
    enable = 1'b0;
  endtask

  task automatic test_down_and_saturate();
    int wraps;
    clear = 1'b1; tick(); clear = 1'b0;
    enable = 1'b1; up = 1'b0; wraps = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("down_out", out_dut, 8'(9 - i));
      chk("down_tc", {7'd0, tc_dut}, {7'd0, i == 9});
      if (wrap_dut) wraps++;
    end
    chk("down_wrap_count", 8'(wraps), 8'd1);
    enable = 1'b0;
    load = 1'b1; data = 8'd9; tick(); load = 1'b0;
    enable = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_up_out", out_sat, 8'd9);
      chk("sat_up_wrap", {7'd0, wrap_sat}, 8'd1);
    end
    clear = 1'b1; enable = 1'b0; tick(); clear = 1'b0;
    enable = 1'b1; up = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sat_down_out", out_sat, 8'd0);
      chk("sat_down_wrap", {7'd0, wrap_sat}, 8'd1);
    end
    enable = 1'b0; tick();
    chk("sat_idle_wrap", {7'd0, wrap_sat}, 8'd0);
  endtask

  task automatic test_load_priority();
    load = 1'b1; data = 8'd200; tick(); load = 1'b0;
    chk("load_clip", out_dut, 8'd9);
    chk("load_no_clip_full", out_full, 8'd200);
    chk("load_no_wrap", {7'd0, wrap_dut}, 8'd0);
    clear = 1'b1; load = 1'b1; enable = 1'b1; up = 1'b1; data = 8'd5;
    tick();
    chk("clear_beats_all", out_dut, 8'd0);
    clear = 1'b0;
    tick();
    chk("load_beats_enable", out_dut, 8'd5);
    load = 1'b0; data = 8'd9; up = 1'b1;
    load = 1'b1; tick(); load = 1'b0;
    chk("load_at_max_no_wrap", {7'd0, wrap_dut}, 8'd0);
    enable = 1'b0;
  endtask

  task automatic test_prescale();
    // Per-edge: enable, load, expected out_pre after the edge.
    logic en_v [15];
    logic ld_v [15];
    logic [7:0] ex_v [15];
    clear = 1'b1; tick(); clear = 1'b0;
    up = 1'b1; data = 8'd50;
`ifdef COUNTER_PRESCALE_EN
    en_v = '{1,1,1,1, 1,1,0,0,1,1, 1,0,1,1,1};
    ld_v = '{0,0,0,0, 0,0,0,0,0,0, 0,1,0,0,0};
    ex_v = '{0,0,0,1, 1,1,1,1,1,2, 2,50,50,50,50};
`else
    en_v = '{1,1,1,1, 1,1,0,0,1,1, 1,0,1,1,1};
    ld_v = '{0,0,0,0, 0,0,0,0,0,0, 0,1,0,0,0};
    ex_v = '{1,2,3,4, 5,6,6,6,7,8, 9,50,51,52,53};
`endif
    for (int i = 0; i < 15; i++) begin
      enable = en_v[i]; load = ld_v[i];
      tick();
      chk("prescale_out", out_pre, ex_v[i]);
    end
    load = 1'b0; enable = 1'b1;
    tick();
`ifdef COUNTER_PRESCALE_EN
    chk("prescale_after_load", out_pre, 8'd51);
`else
    chk("prescale_after_load", out_pre, 8'd54);
`endif
    enable = 1'b0;
  endtask

  task automatic test_alternate_and_soak();
    logic [3:0] m;
    logic       mw;
    load = 1'b1; data = 8'd15; tick(); load = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      up = (i % 2 == 0);
      tick();
      chk("alt_out", {4'd0, out_w4}, (i % 2 == 0) ? 8'd0 : 8'd15);
      chk("alt_wrap", {7'd0, wrap_w4}, 8'd1);
    end
    m = out_w4; mw = wrap_w4;
    if (m !== 4'd15) begin
      tests_run++; fails++;
      $display("FAIL soak_seed: got %0d expected 15", m);
      m = 4'd15;
    end
    for (int i = 0; i < 10000; i++) begin
      clear  = ($urandom_range(15) == 0);
      load   = ($urandom_range(7) == 0);
      enable = ($urandom_range(3) != 0);
      up     = $urandom_range(1);
      data   = 8'($urandom_range(255));
      #1;
      chk("soak_tc", {7'd0, tc_w4}, {7'd0, up ? (m == 4'd15) : (m == 4'd0)});
      mw = 1'b0;
      if (clear)       m = 4'd0;
      else if (load)   m = data[3:0];
      else if (enable) begin
        if (up) begin
          if (m == 4'd15) begin m = 4'd0;  mw = 1'b1; end
          else m = m + 4'd1;
        end else begin
          if (m == 4'd0) begin m = 4'd15; mw = 1'b1; end
          else m = m - 4'd1;
        end
      end
      tick();
      chk("soak_out", {4'd0, out_w4}, {4'd0, m});
      chk("soak_wrap", {7'd0, wrap_w4}, {7'd0, mw});
    end
    clear = 1'b0; load = 1'b0; enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_and_saturate();
    test_load_priority();
    test_prescale();
    test_alternate_and_soak();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
